// File: rtl/reorder_buffer_if.sv
// Reorder buffer handshake bundle: issue, writeback broadcast, operand query,
// retire and flush. The master modport is the core side, slave is the ROB.
interface reorder_buffer_if #(
  parameter int unsigned ROB_POS_WID = 4
);
  // Issue
  logic                   issue_valid;
  logic [4:0]             issue_rd;
  logic                   issue_is_br;
  logic                   issue_pred_taken;
  logic [31:0]            issue_pc;
  logic [ROB_POS_WID-1:0] issue_rob_pos;
  logic                   full;
  // Writeback broadcast
  logic                   wb_valid;
  logic [ROB_POS_WID-1:0] wb_rob_pos;
  logic [31:0]            wb_val;
  logic                   wb_br_taken;
  logic [31:0]            wb_br_target;
  // Operand query
  logic [ROB_POS_WID-1:0] query1_pos;
  logic [ROB_POS_WID-1:0] query2_pos;
  logic                   query1_ready;
  logic                   query2_ready;
  logic [31:0]            query1_val;
  logic [31:0]            query2_val;
  // Retire
  logic                   commit;
  logic [4:0]             commit_rd;
  logic [31:0]            commit_val;
  logic [ROB_POS_WID-1:0] commit_rob_pos;
  // Flush
  logic                   rollback;
  logic [31:0]            rollback_pc;

  modport master (
    output issue_valid, issue_rd, issue_is_br, issue_pred_taken, issue_pc,
    input  issue_rob_pos, full,
    output wb_valid, wb_rob_pos, wb_val, wb_br_taken, wb_br_target,
    output query1_pos, query2_pos,
    input  query1_ready, query2_ready, query1_val, query2_val,
    input  commit, commit_rd, commit_val, commit_rob_pos,
    input  rollback, rollback_pc
  );

  modport slave (
    input  issue_valid, issue_rd, issue_is_br, issue_pred_taken, issue_pc,
    output issue_rob_pos, full,
    input  wb_valid, wb_rob_pos, wb_val, wb_br_taken, wb_br_target,
    input  query1_pos, query2_pos,
    output query1_ready, query2_ready, query1_val, query2_val,
    output commit, commit_rd, commit_val, commit_rob_pos,
    output rollback, rollback_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retire reorder buffer (circular, ROB_SIZE entries).
// Optional feature: define ROB_QUERY_BYPASS_EN to forward a same-cycle
// writeback to the query ports; otherwise queries see stored entries only.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE = 16
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 rdy,
  reorder_buffer_if.slave     rob_if
);
  localparam int unsigned ROB_POS_WID = $clog2(ROB_SIZE);
  localparam int unsigned CntW        = ROB_POS_WID + 1;

  // Pointers and occupancy
  logic [ROB_POS_WID-1:0] head_q, head_d;
  logic [ROB_POS_WID-1:0] tail_q, tail_d;
  logic [CntW-1:0]        count_q, count_d;

  // Per-entry state; busy/ready are reset, payload is not
  logic [ROB_SIZE-1:0] busy_q, busy_d;
  logic [ROB_SIZE-1:0] ready_q, ready_d;
  logic [4:0]          rd_q       [ROB_SIZE];
  logic [4:0]          rd_d       [ROB_SIZE];
  logic [31:0]         val_q      [ROB_SIZE];
  logic [31:0]         val_d      [ROB_SIZE];
  logic                is_br_q    [ROB_SIZE];
  logic                is_br_d    [ROB_SIZE];
  logic                pred_q     [ROB_SIZE];
  logic                pred_d     [ROB_SIZE];
  logic                br_taken_q [ROB_SIZE];
  logic                br_taken_d [ROB_SIZE];
  logic [31:0]         pc_q       [ROB_SIZE];
  logic [31:0]         pc_d       [ROB_SIZE];
  logic [31:0]         target_q   [ROB_SIZE];
  logic [31:0]         target_d   [ROB_SIZE];

  // Registered retire / flush ports
  logic                   commit_q, commit_d;
  logic [4:0]             commit_rd_q, commit_rd_d;
  logic [31:0]            commit_val_q, commit_val_d;
  logic [ROB_POS_WID-1:0] commit_pos_q, commit_pos_d;
  logic                   rollback_q, rollback_d;
  logic [31:0]            rollback_pc_q, rollback_pc_d;

  logic full;
  logic issue_fire;
  logic retire_fire;
  logic mispredict;

  assign full = (count_q == CntW'(ROB_SIZE));

  // Issue is gated by the flush pulse so nothing lands in a buffer being restarted
  assign issue_fire  = rdy && rob_if.issue_valid && !full && !rollback_q;
  assign retire_fire = rdy && (count_q != '0) && ready_q[head_q];
  assign mispredict  = retire_fire && is_br_q[head_q] &&
                       (br_taken_q[head_q] != pred_q[head_q]);

  // Next-state: writeback, retire, issue, then a mispredict flush overrides all
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    busy_d        = busy_q;
    ready_d       = ready_q;
    rd_d          = rd_q;
    val_d         = val_q;
    is_br_d       = is_br_q;
    pred_d        = pred_q;
    br_taken_d    = br_taken_q;
    pc_d          = pc_q;
    target_d      = target_q;
    commit_d      = 1'b0;
    commit_rd_d   = commit_rd_q;
    commit_val_d  = commit_val_q;
    commit_pos_d  = commit_pos_q;
    rollback_d    = 1'b0;
    rollback_pc_d = rollback_pc_q;

    if (rdy) begin
      if (rob_if.wb_valid && busy_q[rob_if.wb_rob_pos]) begin
        ready_d[rob_if.wb_rob_pos]    = 1'b1;
        val_d[rob_if.wb_rob_pos]      = rob_if.wb_val;
        br_taken_d[rob_if.wb_rob_pos] = rob_if.wb_br_taken;
        target_d[rob_if.wb_rob_pos]   = rob_if.wb_br_target;
      end

      if (retire_fire) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + ROB_POS_WID'(1);
        commit_d       = 1'b1;
        commit_rd_d    = rd_q[head_q];
        commit_val_d   = val_q[head_q];
        commit_pos_d   = head_q;
      end

      if (issue_fire) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        rd_d[tail_q]    = rob_if.issue_rd;
        is_br_d[tail_q] = rob_if.issue_is_br;
        pred_d[tail_q]  = rob_if.issue_pred_taken;
        pc_d[tail_q]    = rob_if.issue_pc;
        tail_d          = tail_q + ROB_POS_WID'(1);
      end

      count_d = count_q + CntW'(issue_fire) - CntW'(retire_fire);

      if (mispredict) begin
        busy_d        = '0;
        head_d        = '0;
        tail_d        = '0;
        count_d       = '0;
        rollback_d    = 1'b1;
        rollback_pc_d = br_taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
      end
    end
  end

  // Control state and output ports, synchronously reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      busy_q        <= '0;
      ready_q       <= '0;
      commit_q      <= 1'b0;
      commit_rd_q   <= '0;
      commit_val_q  <= '0;
      commit_pos_q  <= '0;
      rollback_q    <= 1'b0;
      rollback_pc_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      commit_q      <= commit_d;
      commit_rd_q   <= commit_rd_d;
      commit_val_q  <= commit_val_d;
      commit_pos_q  <= commit_pos_d;
      rollback_q    <= rollback_d;
      rollback_pc_q <= rollback_pc_d;
    end
  end

  // Entry payload; only meaningful while busy, so it needs no reset
  always_ff @(posedge clk) begin
    rd_q       <= rd_d;
    val_q      <= val_d;
    is_br_q    <= is_br_d;
    pred_q     <= pred_d;
    br_taken_q <= br_taken_d;
    pc_q       <= pc_d;
    target_q   <= target_d;
  end

  // Operand query, optionally forwarding the in-flight writeback
  always_comb begin
    rob_if.query1_ready = ready_q[rob_if.query1_pos];
    rob_if.query1_val   = val_q[rob_if.query1_pos];
    rob_if.query2_ready = ready_q[rob_if.query2_pos];
    rob_if.query2_val   = val_q[rob_if.query2_pos];
`ifdef ROB_QUERY_BYPASS_EN
    if (rob_if.wb_valid && (rob_if.wb_rob_pos == rob_if.query1_pos)) begin
      rob_if.query1_ready = 1'b1;
      rob_if.query1_val   = rob_if.wb_val;
    end
    if (rob_if.wb_valid && (rob_if.wb_rob_pos == rob_if.query2_pos)) begin
      rob_if.query2_ready = 1'b1;
      rob_if.query2_val   = rob_if.wb_val;
    end
`endif
  end

  assign rob_if.issue_rob_pos  = tail_q;
  assign rob_if.full           = full;
  assign rob_if.commit         = commit_q;
  assign rob_if.commit_rd      = commit_rd_q;
  assign rob_if.commit_val     = commit_val_q;
  assign rob_if.commit_rob_pos = commit_pos_q;
  assign rob_if.rollback       = rollback_q;
  assign rob_if.rollback_pc    = rollback_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based program-order model.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst;
  logic rdy;

  reorder_buffer_if #(.ROB_POS_WID(4)) rif ();

  reorder_buffer #(.ROB_SIZE(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .rdy    (rdy),
    .rob_if (rif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pos;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        is_br;
    logic        pred;
    logic        ready;
    logic [31:0] val;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  // Model: in-flight entries oldest first, plus expected registered outputs
  ent_t        mq[$];
  int          m_tail;
  logic        e_commit;
  logic [4:0]  e_commit_rd;
  logic [31:0] e_commit_val;
  logic [3:0]  e_commit_pos;
  logic        e_rollback;
  logic [31:0] e_rollback_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int seen_commit[$];
  int n_rb;
  logic [31:0] last_rb_pc;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int find(input int pos);
    for (int i = 0; i < mq.size(); i++) if (mq[i].pos == pos) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_tail        = 0;
    e_commit      = 1'b0;
    e_commit_rd   = '0;
    e_commit_val  = '0;
    e_commit_pos  = '0;
    e_rollback    = 1'b0;
    e_rollback_pc = '0;
  endtask

  // Expected query result; chk=0 when the slot holds no live entry
  task automatic query_exp(input logic [3:0] pos, output bit chk, output logic rdy_e,
                           output logic [31:0] val_e);
    int idx;
    idx = find(int'(pos));
    chk = 1'b0; rdy_e = 1'b0; val_e = '0;
`ifdef ROB_QUERY_BYPASS_EN
    if (rif.wb_valid && rif.wb_rob_pos == pos) begin
      chk = 1'b1; rdy_e = 1'b1; val_e = rif.wb_val;
      return;
    end
`endif
    if (idx >= 0) begin
      chk   = 1'b1;
      rdy_e = mq[idx].ready;
      val_e = mq[idx].val;
    end
  endtask

  task automatic check_outputs();
    bit chk;
    logic qr;
    logic [31:0] qv;
    check_eq("full", 32'(rif.full), 32'(mq.size() == 16));
    check_eq("issue_rob_pos", 32'(rif.issue_rob_pos), 32'(m_tail));
    check_eq("commit", 32'(rif.commit), 32'(e_commit));
    check_eq("commit_rd", 32'(rif.commit_rd), 32'(e_commit_rd));
    check_eq("commit_val", rif.commit_val, e_commit_val);
    check_eq("commit_rob_pos", 32'(rif.commit_rob_pos), 32'(e_commit_pos));
    check_eq("rollback", 32'(rif.rollback), 32'(e_rollback));
    check_eq("rollback_pc", rif.rollback_pc, e_rollback_pc);
    query_exp(rif.query1_pos, chk, qr, qv);
    if (chk) begin
      check_eq("query1_ready", 32'(rif.query1_ready), 32'(qr));
      if (qr) check_eq("query1_val", rif.query1_val, qv);
    end
    query_exp(rif.query2_pos, chk, qr, qv);
    if (chk) begin
      check_eq("query2_ready", 32'(rif.query2_ready), 32'(qr));
      if (qr) check_eq("query2_val", rif.query2_val, qv);
    end
  endtask

  // Advance the model across one rising edge with the currently driven inputs
  task automatic model_update();
    ent_t hd, e;
    bit ret, iss;
    int idx;
    if (rst) begin
      model_reset();
      return;
    end
    if (!rdy) begin
      e_commit   = 1'b0;
      e_rollback = 1'b0;
      return;
    end
    ret = (mq.size() > 0) && mq[0].ready;
    if (ret) hd = mq[0];
    iss = rif.issue_valid && (mq.size() < 16) && !e_rollback;
    if (rif.wb_valid) begin
      idx = find(int'(rif.wb_rob_pos));
      if (idx >= 0) begin
        e = mq[idx];
        e.ready = 1'b1; e.val = rif.wb_val; e.taken = rif.wb_br_taken; e.tgt = rif.wb_br_target;
        mq[idx] = e;
      end
    end
    e_commit   = ret;
    e_rollback = 1'b0;
    if (ret) begin
      e_commit_rd  = hd.rd;
      e_commit_val = hd.val;
      e_commit_pos = 4'(hd.pos);
      void'(mq.pop_front());
    end
    if (iss) begin
      e = '{pos: m_tail, rd: rif.issue_rd, pc: rif.issue_pc, is_br: rif.issue_is_br,
            pred: rif.issue_pred_taken, ready: 1'b0, val: '0, taken: 1'b0, tgt: '0};
      mq.push_back(e);
      m_tail = (m_tail + 1) % 16;
    end
    if (ret && hd.is_br && (hd.taken != hd.pred)) begin
      e_rollback    = 1'b1;
      e_rollback_pc = hd.taken ? hd.tgt : hd.pc + 32'd4;
      mq.delete();
      m_tail = 0;
    end
  endtask

  // Called just after a falling edge with inputs driven; returns at the next one
  task automatic step();
    #1;
    check_outputs();
    if (rif.commit) seen_commit.push_back(int'(rif.commit_rob_pos));
    if (rif.rollback) begin
      n_rb++;
      last_rb_pc = rif.rollback_pc;
    end
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1;
    rif.issue_valid = 1'b0; rif.issue_rd = '0; rif.issue_is_br = 1'b0;
    rif.issue_pred_taken = 1'b0; rif.issue_pc = '0;
    rif.wb_valid = 1'b0; rif.wb_rob_pos = '0; rif.wb_val = '0;
    rif.wb_br_taken = 1'b0; rif.wb_br_target = '0;
    rif.query1_pos = '0; rif.query2_pos = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [31:0] pc, input logic br,
                       input logic pred);
    idle();
    rif.issue_valid = 1'b1; rif.issue_rd = rd; rif.issue_pc = pc;
    rif.issue_is_br = br; rif.issue_pred_taken = pred;
  endtask

  task automatic wb(input logic [3:0] pos, input logic [31:0] val, input logic tk,
                    input logic [31:0] tgt);
    idle();
    rif.wb_valid = 1'b1; rif.wb_rob_pos = pos; rif.wb_val = val;
    rif.wb_br_taken = tk; rif.wb_br_target = tgt;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step(); idle();
  endtask

  initial begin
    idle();
    rst = 1'b1; rdy = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    idle();
    step();

    // Single issue, writeback next cycle, commit two cycles after writeback
    issue(5'd5, 32'h0, 1'b0, 1'b0); step();
    wb(4'd0, 32'h1234, 1'b0, 32'h0); step();
    idle(); step();
    #1;
    check_eq("d1_commit", 32'(rif.commit), 32'd1);
    check_eq("d1_commit_rd", 32'(rif.commit_rd), 32'd5);
    check_eq("d1_commit_val", rif.commit_val, 32'h1234);
    check_eq("d1_commit_pos", 32'(rif.commit_rob_pos), 32'd0);
    step();

    // Fill to 16, refuse the 17th, retire one, wrap the tail
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue(5'(i + 1), 32'(i * 4), 1'b0, 1'b0); step();
    end
    issue(5'd31, 32'h40, 1'b0, 1'b0);
    #1;
    check_eq("d2_full", 32'(rif.full), 32'd1);
    check_eq("d2_pos_full", 32'(rif.issue_rob_pos), 32'd0);
    step();
    wb(4'd0, 32'hAA, 1'b0, 32'h0); step();
    idle(); step();
    #1;
    check_eq("d2_not_full", 32'(rif.full), 32'd0);
    check_eq("d2_wrap_pos", 32'(rif.issue_rob_pos), 32'd0);
    issue(5'd7, 32'h80, 1'b0, 1'b0); step();
    idle(); step();

    // Out-of-order writebacks retire in program order on consecutive cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(5'(i + 1), 32'(i * 4), 1'b0, 1'b0); step();
    end
    seen_commit.delete();
    wb(4'd2, 32'h22, 1'b0, 32'h0); step();
    wb(4'd0, 32'h00, 1'b0, 32'h0); step();
    wb(4'd1, 32'h11, 1'b0, 32'h0); step();
    idle(); repeat (4) step();
    check_eq("d3_ncommit", 32'(seen_commit.size()), 32'd3);
    for (int i = 0; i < 3 && i < seen_commit.size(); i++)
      check_eq("d3_order", 32'(seen_commit[i]), 32'(i));

    // Mispredicted branch flushes younger, already-completed entries
    do_reset();
    seen_commit.delete();
    n_rb = 0;
    issue(5'd0, 32'h100, 1'b1, 1'b0); step();
    issue(5'd3, 32'h104, 1'b0, 1'b0); step();
    issue(5'd4, 32'h108, 1'b0, 1'b0); step();
    wb(4'd1, 32'h1, 1'b0, 32'h0); step();
    wb(4'd2, 32'h2, 1'b0, 32'h0); step();
    wb(4'd0, 32'h0, 1'b1, 32'h200); step();
    idle(); repeat (4) step();
    check_eq("d4_nrb", 32'(n_rb), 32'd1);
    check_eq("d4_rb_pc", last_rb_pc, 32'h200);
    check_eq("d4_ncommit", 32'(seen_commit.size()), 32'd1);
    #1;
    check_eq("d4_pos", 32'(rif.issue_rob_pos), 32'd0);
    check_eq("d4_full", 32'(rif.full), 32'd0);

    // Query sees a writeback same cycle with bypass, next cycle without
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(5'(i + 1), 32'(i * 4), 1'b0, 1'b0); step();
    end
    wb(4'd3, 32'h55, 1'b0, 32'h0);
    rif.query1_pos = 4'd3;
    #1;
`ifdef ROB_QUERY_BYPASS_EN
    check_eq("d5_q_same", 32'(rif.query1_ready), 32'd1);
    check_eq("d5_v_same", rif.query1_val, 32'h55);
`else
    check_eq("d5_q_same", 32'(rif.query1_ready), 32'd0);
`endif
    step();
    idle(); rif.query1_pos = 4'd3;
    #1;
    check_eq("d5_q_next", 32'(rif.query1_ready), 32'd1);
    check_eq("d5_v_next", rif.query1_val, 32'h55);
    step();

    // Reset with rdy low while busy and a commit pending
    do_reset();
    for (int i = 0; i < 5; i++) begin
      issue(5'(i + 9), 32'(i * 4), 1'b0, 1'b0); step();
    end
    wb(4'd0, 32'h77, 1'b0, 32'h0); step();
    idle(); step();
    idle(); rst = 1'b1; rdy = 1'b0; step();
    idle();
    #1;
    check_eq("d6_commit", 32'(rif.commit), 32'd0);
    check_eq("d6_commit_rd", 32'(rif.commit_rd), 32'd0);
    check_eq("d6_commit_val", rif.commit_val, 32'd0);
    check_eq("d6_full", 32'(rif.full), 32'd0);
    check_eq("d6_pos", 32'(rif.issue_rob_pos), 32'd0);
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int idx;
      idle();
      rst = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      rif.issue_valid      = ($urandom_range(0, 9) < 6);
      rif.issue_is_br      = ($urandom_range(0, 3) == 0);
      rif.issue_rd         = rif.issue_is_br ? 5'd0 : 5'($urandom);
      rif.issue_pred_taken = 1'($urandom);
      rif.issue_pc         = $urandom & 32'hFFFF_FFFC;
      rif.wb_valid         = ($urandom_range(0, 9) < 7);
      rif.wb_val           = $urandom;
      rif.wb_br_target     = $urandom & 32'hFFFF_FFFC;
      rif.wb_br_taken      = 1'($urandom);
      rif.wb_rob_pos       = 4'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        idx = $urandom_range(0, mq.size() - 1);
        rif.wb_rob_pos = 4'(mq[idx].pos);
        if (mq[idx].is_br)
          rif.wb_br_taken = ($urandom_range(0, 3) == 0) ? !mq[idx].pred : mq[idx].pred;
      end
      rif.query1_pos = ($urandom_range(0, 1) == 0) ? rif.wb_rob_pos : 4'($urandom);
      rif.query2_pos = 4'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_SIZE, 16, entry count (power of two); ROB_POS_WID = log2(ROB_SIZE) = 4.
REQ-002 Reset rst SHALL be synchronous and active-high; the clock SHALL be clk.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 rdy  in  1  global enable; when 0, all state SHALL hold.
REQ-006 issue_valid  in  1  decoder requests an entry.
REQ-007 issue_rd  in  5  destination register; 0 means no write.
REQ-008 issue_is_br, issue_pred_taken  in  1 each  branch flag and its prediction.
REQ-009 issue_pc  in  32  instruction PC.
REQ-010 issue_rob_pos  out  4  position the next accepted issue receives (equals tail).
REQ-011 full  out  1  count == ROB_SIZE.
REQ-012 wb_valid, wb_rob_pos[4], wb_val[32], wb_br_taken[1], wb_br_target[32]  in  result broadcast.
REQ-013 query1_pos/query2_pos  in  4; query1_ready/query2_ready  out  1; query1_val/query2_val  out  32.
REQ-014 commit  out  1; commit_rd  out  5; commit_val  out  32; commit_rob_pos  out  4: registered retire port.
REQ-015 rollback  out  1; rollback_pc  out  32: registered flush request.

Function
REQ-016 Circular buffer: head, tail (4 bits, wrap ROB_SIZE-1 -> 0) and count (0..ROB_SIZE); each entry holds busy, ready, rd, val, is_br, pred_taken, br_taken, pc, target.
REQ-017 Issue SHALL be accepted on a rising edge iff rdy && issue_valid && !full && !rollback; it writes entry[tail] (busy=1, ready=0), increments tail.
REQ-018 full SHALL use current count; an issue at count==16 SHALL be refused even when a commit retires in the same cycle.
REQ-019 Writeback with rdy && wb_valid to a busy entry SHALL set ready=1 and store val/br_taken/target; writeback to a non-busy entry SHALL be ignored.
REQ-020 Retire: when rdy && count>0 && entry[head].ready, the next edge SHALL assert commit for one cycle with that entry's rd/val/pos, clear busy, increment head.
REQ-021 At most one retire per cycle; simultaneous issue and retire SHALL leave count unchanged.
REQ-022 Latency: issue at edge E0, writeback in cycle 1 -> commit high in cycle 3 (ready registered at end of cycle 1, retire at end of cycle 2).
REQ-023 A retiring branch with br_taken != pred_taken SHALL, on the same edge, assert rollback for one cycle with rollback_pc = br_taken ? target : pc+4, and clear all busy bits, head=tail=count=0.
REQ-024 Branches SHALL retire with commit_rd as issued (normally 0); commit and rollback may be high in the same cycle.
REQ-025 Query: query_ready = entry[pos].ready, query_val = entry[pos].val, combinational.
REQ-026 commit and rollback SHALL be 0 in any cycle following an edge where rdy was 0.

Reset
REQ-027 On rst, head, tail, count, all busy/ready bits, commit, commit_rd, commit_val, commit_rob_pos, rollback, rollback_pc SHALL be 0, regardless of rdy.
REQ-028 Reset mid-operation SHALL discard all in-flight entries; full=0, issue_rob_pos=0 in the next cycle.

Configuration
REQ-029 Macro ROB_QUERY_BYPASS_EN: defined -> if wb_valid && wb_rob_pos == queryN_pos, queryN_ready=1 and queryN_val=wb_val in the same cycle; undefined -> query reflects stored entry only (one cycle later).

Verification
REQ-030 Issue rd=5 at pos 0, wb pos 0 val 0x1234 next cycle -> commit=1, commit_rd=5, commit_val=0x1234, commit_rob_pos=0 two cycles after wb.
REQ-031 Issue 16 without wb -> full=1, 17th issue refused, issue_rob_pos=0; wb pos 0 -> one retire, full=0, next issue gets pos 0 (wrap).
REQ-032 Wb pos 2 then pos 0 then pos 1 -> commits in order 0,1,2 on consecutive cycles.
REQ-033 Branch pc=0x100 pred_taken=0, wb br_taken=1 target=0x200 -> rollback=1, rollback_pc=0x200, count=0; younger entries never commit.
REQ-034 Wb pos 3 val 0x55 with query1_pos=3 -> query1_ready=1, val 0x55 same cycle with ROB_QUERY_BYPASS_EN, next cycle without.
REQ-035 rst asserted with 5 entries busy and rdy=0 -> all outputs 0, count=0 next cycle.
